// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execution-control sequencer.
//   state_t    - 3-bit sequencer state; the codes are visible on exec_ctrl.mode
//   STEP_CNT_W - width of the issued-step counter
package exec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STEP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FAST = 3'd3,
    ST_EDIT = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam int STEP_CNT_W = 8;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: brings an asynchronous panel level into the clk domain and
// flags its rising edges.
//   clk   - system clock
//   rst   - asynchronous active-low reset
//   din   - asynchronous input level
//   level - synchronized level (two flops after din)
//   rise  - one-cycle pulse when the synchronized level goes 0 -> 1
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  // A held input yields exactly one pulse: prev catches up one cycle later.
  assign rise  = sync & ~prev;

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: front-panel execution sequencer. Converts the panel controls into
// a single-cycle step enable for the CPU core.
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   next       - single-step request (async level)
//   run        - run/stop toggle (async level)
//   speedRun   - fast-run request (async level)
//   edit       - programming mode (async level)
//   halt       - core halt indication (synchronous to clk)
//   step       - one-cycle instruction-advance pulse
//   mode       - current state code (see exec_pkg::state_t)
//   busy       - high while in RUN or FAST
//   step_count - number of step pulses since reset, wrapping
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int SLOW_DIV = 25_000_000,
  parameter int FAST_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  next,
  input  logic                  run,
  input  logic                  speedRun,
  input  logic                  edit,
  input  logic                  halt,
  output logic                  step,
  output logic [2:0]            mode,
  output logic                  busy,
  output logic [STEP_CNT_W-1:0] step_count
);

  // One counter serves both rates; FAST_DIV is never larger than SLOW_DIV.
  localparam int                CNT_W    = $clog2(SLOW_DIV);
  localparam logic [CNT_W-1:0]  SLOW_TOP = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0]  FAST_TOP = CNT_W'(FAST_DIV - 1);

  logic next_rise;
  logic run_rise;
  logic speed_rise;
  logic edit_level;
  logic next_level_unused;
  logic run_level_unused;
  logic speed_level_unused;
  logic edit_rise_unused;

  sync_edge u_sync_next (
    .clk   (clk),
    .rst   (rst),
    .din   (next),
    .level (next_level_unused),
    .rise  (next_rise)
  );

  sync_edge u_sync_run (
    .clk   (clk),
    .rst   (rst),
    .din   (run),
    .level (run_level_unused),
    .rise  (run_rise)
  );

  sync_edge u_sync_speed (
    .clk   (clk),
    .rst   (rst),
    .din   (speedRun),
    .level (speed_level_unused),
    .rise  (speed_rise)
  );

  sync_edge u_sync_edit (
    .clk   (clk),
    .rst   (rst),
    .din   (edit),
    .level (edit_level),
    .rise  (edit_rise_unused)
  );

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_top;
  logic             running;
  logic             tick;

  assign running = (state_q == ST_RUN) || (state_q == ST_FAST);
  assign cnt_top = (state_q == ST_FAST) ? FAST_TOP : SLOW_TOP;
  assign tick    = running && (cnt_q == cnt_top);

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (edit_level) begin
      state_d = ST_EDIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (speed_rise)     state_d = ST_FAST;
          else if (run_rise)  state_d = ST_RUN;
          else if (next_rise) state_d = ST_STEP;
        end
        ST_STEP: state_d = ST_IDLE;
        ST_RUN: begin
          if (halt)            state_d = ST_HALT;
          else if (speed_rise) state_d = ST_FAST;
          else if (run_rise)   state_d = ST_IDLE;
        end
        ST_FAST: begin
          if (halt)                        state_d = ST_HALT;
          else if (speed_rise || run_rise) state_d = ST_IDLE;
        end
        // edit_level is already known low on this branch.
        ST_EDIT: state_d = ST_IDLE;
        ST_HALT: begin
          if (!halt) state_d = ST_IDLE;
        end
        // Codes 6 and 7 are unreachable but recover to IDLE.
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The prescaler only advances while staying in RUN or FAST; any entry,
  // exit or RUN<->FAST switch restarts it from zero.
  always_comb begin
    cnt_d = '0;
    if (running && (state_d == state_q)) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      step_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (step) step_count <= step_count + STEP_CNT_W'(1);
    end
  end

  // step comes from registered state and count; halt (already synchronous)
  // and the synchronized edit level only veto a continuous-run pulse in the
  // cycle they take priority.
  assign step = (state_q == ST_STEP) || (tick && !halt && !edit_level);
  assign mode = state_q;
  assign busy = running;

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: randomized self-checking bench for exec_ctrl with a
// cycle-level behavioural model of the panel sequencer.
module tb_exec_ctrl;

  localparam int SLOW_DIV = 4;
  localparam int FAST_DIV = 1;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       next     = 1'b0;
  logic       run      = 1'b0;
  logic       speedRun = 1'b0;
  logic       edit     = 1'b0;
  logic       halt     = 1'b0;
  logic       step;
  logic [2:0] mode;
  logic       busy;
  logic [7:0] step_count;

  int n_tests = 0;
  int n_fail  = 0;

  exec_ctrl #(.SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .next       (next),
    .run        (run),
    .speedRun   (speedRun),
    .edit       (edit),
    .halt       (halt),
    .step       (step),
    .mode       (mode),
    .busy       (busy),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {step, mode, busy, step_count};

  // Reference model. States use the published codes 0..5. m_k counts cycles
  // spent continuously in the current RUN/FAST stay; a step is due when
  // m_k mod divider hits divider-1. hX[0] is the newest clock-edge sample.
  int          m_st, m_nst, m_k, m_cnt, m_div;
  bit [2:0]    hn, hr, hs, he;
  bit          m_busy, m_step, m_edit, rn, rr, rs;
  logic [12:0] exp_v;

  always_comb begin
    m_edit = he[1];
    rn     = hn[1] && !hn[2];
    rr     = hr[1] && !hr[2];
    rs     = hs[1] && !hs[2];
    m_busy = (m_st == 2) || (m_st == 3);
    m_div  = (m_st == 3) ? FAST_DIV : SLOW_DIV;
    m_step = (m_st == 1) || (m_busy && (m_k % m_div) == m_div - 1 && !halt && !m_edit);
    exp_v  = {m_step, 3'(m_st), m_busy, 8'(m_cnt)};
    m_nst  = m_st;
    if (m_edit) m_nst = 4;
    else begin
      case (m_st)
        0: begin
          if (rs) m_nst = 3;
          else if (rr) m_nst = 2;
          else if (rn) m_nst = 1;
        end
        1: m_nst = 0;
        2: begin
          if (halt) m_nst = 5;
          else if (rs) m_nst = 3;
          else if (rr) m_nst = 0;
        end
        3: begin
          if (halt) m_nst = 5;
          else if (rs || rr) m_nst = 0;
        end
        4: m_nst = 0;
        5: if (!halt) m_nst = 0;
        default: m_nst = 0;
      endcase
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st  <= 0;
      m_k   <= 0;
      m_cnt <= 0;
      hn    <= '0;
      hr    <= '0;
      hs    <= '0;
      he    <= '0;
    end else begin
      m_st  <= m_nst;
      m_k   <= (m_nst == m_st && m_busy) ? m_k + 1 : 0;
      m_cnt <= m_step ? (m_cnt + 1) % 256 : m_cnt;
      hn    <= {hn[1:0], next};
      hr    <= {hr[1:0], run};
      hs    <= {hs[1:0], speedRun};
      he    <= {he[1:0], edit};
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (obs !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h, expected 0000", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL after_reset c=%0d: got %h, expected %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_single_step();
    int steps = 0;
    int first = -1;
    for (int c = 0; c < 12; c++) begin
      next = (c < 5);
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_step c=%0d: got %h, expected %h", c, obs, exp_v);
      end
      if (step === 1'b1) begin
        steps++;
        if (first < 0) first = c;
      end
    end
    n_tests++;
    if (steps != 1 || first != 2 || step_count !== 8'd1 || mode !== 3'd0) begin
      n_fail++;
      $display("FAIL single_step_summary: got pulses=%0d at=%0d count=%0d mode=%0d, expected 1 at 2 count=1 mode=0",
               steps, first, step_count, mode);
    end
  endtask

  task automatic test_back_to_back();
    int steps = 0;
    for (int c = 0; c < 12; c++) begin
      next = (c < 6) && (c % 2 == 0);
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d: got %h, expected %h", c, obs, exp_v);
      end
      if (step === 1'b1) steps++;
    end
    n_tests++;
    if (steps != 3 || step_count !== 8'd4) begin
      n_fail++;
      $display("FAIL back_to_back_summary: got pulses=%0d count=%0d, expected 3 count=4", steps, step_count);
    end
  endtask

  task automatic test_slow_run();
    int steps = 0;
    int last  = -1;
    int c     = 0;
    run = 1'b1;
    while (steps < 3 && c < 60) begin
      if (c == 2) run = 1'b0;
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL slow_run c=%0d: got %h, expected %h", c, obs, exp_v);
      end
      if (step === 1'b1) begin
        if (last >= 0) begin
          n_tests++;
          if (c - last != SLOW_DIV) begin
            n_fail++;
            $display("FAIL slow_run_spacing: got %0d cycles, expected %0d", c - last, SLOW_DIV);
          end
        end
        last = c;
        steps++;
      end
      c++;
    end
    n_tests++;
    if (steps != 3) begin
      n_fail++;
      $display("FAIL slow_run_timeout: got %0d steps, expected 3 within 60 cycles", steps);
    end
    for (int i = 0; i < 8; i++) begin
      run = (i < 2);
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL slow_run_stop i=%0d: got %h, expected %h", i, obs, exp_v);
      end
    end
    n_tests++;
    if (mode !== 3'd0 || step_count !== 8'd7 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL slow_run_summary: got mode=%0d count=%0d busy=%b, expected 0/7/0", mode, step_count, busy);
    end
  endtask

  task automatic test_fast();
    bit saw_wrap = 1'b0;
    logic [7:0] prev_cnt = 8'd0;
    for (int c = 0; c < 282; c++) begin
      run      = (c < 2);
      speedRun = (c >= 6) && (c < 8);
      next     = (c >= 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL fast c=%0d: got %h, expected %h", c, obs, exp_v);
      end
      if (prev_cnt == 8'd255 && step_count == 8'd0) saw_wrap = 1'b1;
      prev_cnt = step_count;
    end
    next = 1'b0;
    n_tests++;
    if (!saw_wrap || mode !== 3'd3 || step !== 1'b1) begin
      n_fail++;
      $display("FAIL fast_summary: got wrap=%b mode=%0d step=%b, expected 1/3/1", saw_wrap, mode, step);
    end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    #1;
    n_tests++;
    if (step !== 1'b0 || mode !== 3'd3) begin
      n_fail++;
      $display("FAIL halt_same_cycle: got step=%b mode=%0d, expected 0/3", step, mode);
    end
    for (int c = 0; c < 12; c++) begin
      halt     = (c < 8);
      next     = (c < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      run      = (c < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      speedRun = (c < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL halt c=%0d: got %h, expected %h", c, obs, exp_v);
      end
      if (c == 4) begin
        n_tests++;
        if (mode !== 3'd5 || step !== 1'b0) begin
          n_fail++;
          $display("FAIL halt_hold: got mode=%0d step=%b, expected 5/0", mode, step);
        end
      end
    end
    n_tests++;
    if (mode !== 3'd0) begin
      n_fail++;
      $display("FAIL halt_release: got mode=%0d, expected 0", mode);
    end
  endtask

  task automatic test_edit();
    int late_steps = 0;
    for (int c = 0; c < 28; c++) begin
      run  = (c < 2);
      edit = (c >= 8) && (c < 20);
      next = (c >= 9 && c < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL edit c=%0d: got %h, expected %h", c, obs, exp_v);
      end
      if (c >= 10 && step === 1'b1) late_steps++;
      if (c == 10) begin
        n_tests++;
        if (mode !== 3'd4) begin
          n_fail++;
          $display("FAIL edit_enter: got mode=%0d, expected 4", mode);
        end
      end
    end
    n_tests++;
    if (late_steps != 0 || mode !== 3'd0) begin
      n_fail++;
      $display("FAIL edit_summary: got steps=%0d mode=%0d, expected 0/0", late_steps, mode);
    end
  endtask

  task automatic test_async_reset();
    int c = 0;
    int after = 0;
    run = 1'b1;
    while (c < 30 && !(step === 1'b1 && busy === 1'b1)) begin
      if (c == 2) run = 1'b0;
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL async_reset_run c=%0d: got %h, expected %h", c, obs, exp_v);
      end
      c++;
    end
    run = 1'b0;
    n_tests++;
    if (c >= 30) begin
      n_fail++;
      $display("FAIL async_reset_timeout: got no RUN step, expected one within 30 cycles");
    end
    #1 rst = 1'b0;
    #1;
    n_tests++;
    if (obs !== 13'h0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %h, expected 0000", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL async_reset_after i=%0d: got %h, expected %h", i, obs, exp_v);
      end
      if (step === 1'b1) after++;
    end
    n_tests++;
    if (after != 0) begin
      n_fail++;
      $display("FAIL async_reset_quiet: got %0d steps, expected 0", after);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) next     = ~next;
      if ($urandom_range(0, 9) == 0) run      = ~run;
      if ($urandom_range(0, 11) == 0) speedRun = ~speedRun;
      if ($urandom_range(0, 39) == 0) edit    = ~edit;
      halt = (m_busy || m_st == 5) ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random c=%0d: got %h, expected %h", c, obs, exp_v);
      end
    end
    next = 1'b0; run = 1'b0; speedRun = 1'b0; edit = 1'b0; halt = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_step();
    test_back_to_back();
    test_slow_run();
    test_fast();
    test_halt();
    test_edit();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
